// File: rtl/imem_pkg.sv
// Shared encodings for the instruction-memory arbiter and its sibling arbiters.
// Holds the read-owner tags, the FSM state encoding and the default memory geometry.
package imem_pkg;

    localparam int DefInctWidth = 32;
    localparam int DefInctNum   = 1024;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester-side bus of the instruction-memory arbiter: CPU fetch port and loader port.
// master = requesters (CPU / loader), slave = the arbiter.
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int Width     = 32,
    parameter int InctWidth = DefInctWidth
);

    logic                 f_req;
    logic [Width-1:0]     f_addr;
    logic                 f_gnt;
    logic                 f_rvalid;
    logic [InctWidth-1:0] f_rdata;

    logic                 l_req;
    logic                 l_we;
    logic [Width-1:0]     l_addr;
    logic [InctWidth-1:0] l_wdata;
    logic                 l_gnt;
    logic                 l_rvalid;
    logic [InctWidth-1:0] l_rdata;

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata
    );

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata
    );

endinterface

// File: rtl/imem_prio_sel.sv
// Two-requester winner select: the priority requester wins unless its burst count
// has reached MaxBurst while the alternate requester is waiting.
module imem_prio_sel #(
    parameter int MaxBurst = 4
) (
    input  logic       pri_req,
    input  logic       alt_req,
    input  logic [3:0] burst_cnt,
    output logic       pri_gnt,
    output logic       alt_gnt
);

    logic cap_hit;

    assign cap_hit = (burst_cnt == 4'(MaxBurst));
    assign pri_gnt = pri_req && !(alt_req && cap_hit);
    assign alt_gnt = alt_req && !pri_gnt;

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one registered-read instruction memory between CPU fetch and the loader.
// Build option IMEM_ARB_ALIGN_CHECK_EN adds err_align and suppresses misaligned accesses.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int Width     = 32,
    parameter int InctWidth = DefInctWidth,
    parameter int InctNum   = DefInctNum,
    parameter int MaxBurst  = 4,
    localparam int AW       = $clog2(InctNum)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_arbiter_if.slave        bus,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [InctWidth-1:0] mem_wdata,
    input  logic [InctWidth-1:0] mem_rdata,
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    output logic                 err_align,
`endif
    output logic                 err_range
);

    localparam logic [Width-3:0] Depth = (Width-2)'(InctNum);

    state_e               state_q, state_d;
    owner_e               rd_owner;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_zero_q, rd_zero_d;
    logic [3:0]           burst_q, burst_d;
    logic                 f_win, l_win;
    logic                 f_oob, l_oob, f_mis, l_mis, f_bad, l_bad;
    logic [InctWidth-1:0] resp_data, f_hold_q, l_hold_q;

    imem_prio_sel #(.MaxBurst(MaxBurst)) u_prio_sel (
        .pri_req  (bus.l_req),
        .alt_req  (bus.f_req),
        .burst_cnt(burst_q),
        .pri_gnt  (l_win),
        .alt_gnt  (f_win)
    );

    assign f_oob = (bus.f_addr[Width-1:2] >= Depth);
    assign l_oob = (bus.l_addr[Width-1:2] >= Depth);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    assign f_mis = |bus.f_addr[1:0];
    assign l_mis = |bus.l_addr[1:0];
`else
    assign f_mis = 1'b0;
    assign l_mis = 1'b0;
`endif
    assign f_bad = f_oob | f_mis;
    assign l_bad = l_oob | l_mis;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        state_d   = S_IDLE;
        rd_pend_d = 1'b0;
        rd_zero_d = 1'b0;
        burst_d   = burst_q;
        bus.f_gnt = 1'b0;
        bus.l_gnt = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (l_win) begin
            state_d   = S_LOAD;
            bus.l_gnt = 1'b1;
            mem_en    = !l_bad;
            mem_we    = bus.l_we && !l_bad;
            mem_addr  = bus.l_addr[AW+1:2];
            mem_wdata = bus.l_wdata;
            rd_pend_d = !bus.l_we;
            rd_zero_d = l_bad;
        end else if (f_win) begin
            state_d   = S_FETCH;
            bus.f_gnt = 1'b1;
            mem_en    = !f_bad;
            mem_addr  = bus.f_addr[AW+1:2];
            rd_pend_d = 1'b1;
            rd_zero_d = f_bad;
        end
        // The cap only matters while fetch is actually waiting.
        if (!bus.f_req || f_win) begin
            burst_d = '0;
        end else if (l_win && burst_q != 4'(MaxBurst)) begin
            burst_d = burst_q + 4'd1;
        end
    end

    // The last winner plus a read-pending flag identifies who owns the response in flight.
    always_comb begin
        rd_owner = OWN_NONE;
        if (rd_pend_q) begin
            rd_owner = (state_q == S_FETCH) ? OWN_FETCH : OWN_LOAD;
        end
    end

    assign resp_data    = rd_zero_q ? '0 : mem_rdata;
    assign bus.f_rvalid = (rd_owner == OWN_FETCH);
    assign bus.l_rvalid = (rd_owner == OWN_LOAD);
    assign bus.f_rdata  = bus.f_rvalid ? resp_data : f_hold_q;
    assign bus.l_rdata  = bus.l_rvalid ? resp_data : l_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_pend_q <= 1'b0;
            rd_zero_q <= 1'b0;
            burst_q   <= '0;
            f_hold_q  <= '0;
            l_hold_q  <= '0;
            err_range <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            rd_zero_q <= rd_zero_d;
            burst_q   <= burst_d;
            if (bus.f_rvalid) f_hold_q <= resp_data;
            if (bus.l_rvalid) l_hold_q <= resp_data;
            err_range <= err_range | (bus.f_gnt & f_oob) | (bus.l_gnt & l_oob);
        end
    end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_align <= 1'b0;
        end else begin
            err_align <= err_align | (bus.f_gnt & f_mis) | (bus.l_gnt & l_mis);
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed cases plus randomized traffic,
// checked by a transaction-level model with a response scoreboard.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int Width     = 32;
    localparam int InctWidth = 32;
    localparam int InctNum   = 1024;
    localparam int MaxBurst  = 4;
    localparam int AW        = $clog2(InctNum);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 mem_en, mem_we;
    logic [AW-1:0]        mem_addr;
    logic [InctWidth-1:0] mem_wdata, mem_rdata;
    logic                 err_range;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    logic                 err_align;
`endif

    always #5 clk = ~clk;

    imem_arbiter_if #(.Width(Width), .InctWidth(InctWidth)) bus ();

    imem_arbiter #(
        .Width(Width), .InctWidth(InctWidth), .InctNum(InctNum), .MaxBurst(MaxBurst)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        .err_align(err_align),
`endif
        .err_range(err_range)
    );

    // Registered-read instruction memory driven by the DUT.
    logic [31:0] phys [InctNum];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) phys[mem_addr] <= mem_wdata;
            else        mem_rdata <= phys[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { int stamp; logic [31:0] data; } resp_t;
    logic [31:0] ref_mem [InctNum];
    resp_t       fq[$], lq[$];
    logic [31:0] f_last = 0, l_last = 0;
    bit          err_model = 0, align_model = 0;
    int          streak = 0;
    int          cyc = 0;

    // Pending requests (held until granted)
    bit          fp = 0, lp = 0, lw = 0;
    logic [31:0] fa = 0, la = 0, ld = 0;

    function automatic bit oob(logic [31:0] a);
        return (a >> 2) >= InctNum;
    endfunction

    function automatic bit mis(logic [31:0] a);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return (a & 32'h0) != 0;
`endif
    endfunction

    function automatic bit bad(logic [31:0] a);
        return oob(a) || mis(a);
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        if (bad(a)) return 32'h0;
        return ref_mem[a[AW+1:2]];
    endfunction

    // One bus cycle: present pending requests, predict and check the arbitration.
    task automatic step(output bit fg, output bit lg);
        logic [31:0] a;
        @(posedge clk);
        #1;
        bus.f_req   = fp;
        bus.f_addr  = fa;
        bus.l_req   = lp;
        bus.l_we    = lw;
        bus.l_addr  = la;
        bus.l_wdata = ld;
        @(negedge clk);
        lg = lp && !(fp && streak == MaxBurst);
        fg = fp && !lg;
        check("f_gnt", 32'(bus.f_gnt), 32'(fg));
        check("l_gnt", 32'(bus.l_gnt), 32'(lg));
        a = lg ? la : fa;
        if (fg || lg) begin
            check("mem_en", 32'(mem_en), 32'(!bad(a)));
            if (!bad(a)) begin
                check("mem_addr", 32'(mem_addr), 32'(a[AW+1:2]));
                check("mem_we", 32'(mem_we), 32'(lg && lw));
                if (lg && lw) check("mem_wdata", mem_wdata, ld);
            end
            if (oob(a)) err_model = 1;
            if (mis(a)) align_model = 1;
            if (lg && lw) begin
                if (!bad(a)) ref_mem[a[AW+1:2]] = ld;
            end else if (lg) begin
                lq.push_back('{stamp: cyc, data: ref_read(a)});
            end else begin
                fq.push_back('{stamp: cyc, data: ref_read(a)});
            end
        end else begin
            check("mem_en_idle", 32'(mem_en), 32'h0);
        end
        if (!fp || fg) streak = 0;
        else if (lg) streak++;
        if (fg) fp = 0;
        if (lg) lp = 0;
    endtask

    task automatic tick();
        bit fg, lg;
        step(fg, lg);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (fp || lp); k++) tick();
        checks++;
        if (fp || lp) begin
            errors++;
            $display("FAIL drain: requests still pending fp=%0d lp=%0d", fp, lp);
            fp = 0;
            lp = 0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'(4 * InctNum + 4 * $urandom_range(0, 255));
        if (r == 1) return 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
        return 32'(4 * $urandom_range(0, 31));
    endfunction

    // Monitor: response ports and sticky flags, sampled after each rising edge.
    initial begin
        resp_t e;
        bit    ev;
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            if (rst_n) begin
                while (fq.size() > 0 && fq[0].stamp < cyc - 1) void'(fq.pop_front());
                while (lq.size() > 0 && lq[0].stamp < cyc - 1) void'(lq.pop_front());
                ev = fq.size() > 0 && fq[0].stamp == cyc - 1;
                check("f_rvalid", 32'(bus.f_rvalid), 32'(ev));
                if (ev) begin
                    e = fq.pop_front();
                    check("f_rdata", bus.f_rdata, e.data);
                    f_last = e.data;
                end else begin
                    check("f_rdata_hold", bus.f_rdata, f_last);
                end
                ev = lq.size() > 0 && lq[0].stamp == cyc - 1;
                check("l_rvalid", 32'(bus.l_rvalid), 32'(ev));
                if (ev) begin
                    e = lq.pop_front();
                    check("l_rdata", bus.l_rdata, e.data);
                    l_last = e.data;
                end else begin
                    check("l_rdata_hold", bus.l_rdata, l_last);
                end
                check("err_range", 32'(err_range), 32'(err_model));
`ifdef IMEM_ARB_ALIGN_CHECK_EN
                check("err_align", 32'(err_align), 32'(align_model));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit    fg, lg;
        string seq;
        logic [31:0] v;

        bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we = 0;
        bus.l_addr = 0; bus.l_wdata = 0;
        for (int i = 0; i < InctNum; i++) begin
            v = $urandom;
            phys[i] = v;
            ref_mem[i] = v;
        end
        phys[2] = 32'h0050_0093;
        ref_mem[2] = 32'h0050_0093;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_f_rvalid", 32'(bus.f_rvalid), 32'h0);
        check("rst_l_rvalid", 32'(bus.l_rvalid), 32'h0);
        check("rst_f_rdata", bus.f_rdata, 32'h0);
        check("rst_l_rdata", bus.l_rdata, 32'h0);
        check("rst_err_range", 32'(err_range), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        rst_n = 1;

        // Fetch of word 2
        fp = 1; fa = 32'h8; tick();
        tick();

        // Loader write then readback
        lp = 1; lw = 1; la = 32'h10; ld = 32'hDEAD_BEEF; tick();
        lp = 1; lw = 0; tick();
        tick();

        // Both requesting continuously: burst cap pattern
        tick();
        seq = "";
        for (int i = 0; i < 10; i++) begin
            if (!fp) begin fp = 1; fa = 32'(4 * i); end
            if (!lp) begin lp = 1; lw = 0; la = 32'(4 * $urandom_range(0, 31)); end
            step(fg, lg);
            seq = {seq, lg ? "L" : (fg ? "F" : "-")};
        end
        checks++;
        if (seq != "LLLLFLLLLF") begin
            errors++;
            $display("FAIL burst_seq: got %s, expected LLLLFLLLLF", seq);
        end
        drain();

        // Out-of-range fetch read and loader write
        fp = 1; fa = 32'(4 * InctNum); tick();
        tick();
        lp = 1; lw = 1; la = 32'(4 * InctNum + 8); ld = 32'h1234_5678; tick();
        tick();

        // Misaligned fetch
        fp = 1; fa = 32'h6; tick();
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (!fp && $urandom_range(0, 3) != 0) begin fp = 1; fa = rand_addr(); end
            if (!lp && $urandom_range(0, 2) == 0) begin
                lp = 1; lw = ($urandom_range(0, 1) == 1); la = rand_addr(); ld = $urandom;
            end
            tick();
        end
        drain();
        tick();

        // Reset asserted right after a loader read grant
        lp = 1; lw = 0; la = 32'h10; tick();
        rst_n = 0;
        fq.delete(); lq.delete();
        f_last = 0; l_last = 0; err_model = 0; align_model = 0; streak = 0;
        bus.f_req = 0; bus.l_req = 0;
        #1;
        check("arst_f_rvalid", 32'(bus.f_rvalid), 32'h0);
        check("arst_l_rvalid", 32'(bus.l_rvalid), 32'h0);
        check("arst_f_rdata", bus.f_rdata, 32'h0);
        check("arst_l_rdata", bus.l_rdata, 32'h0);
        check("arst_err_range", 32'(err_range), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        tick();
        tick();

        // Normal operation after reset
        fp = 1; fa = 32'h8; tick();
        tick();
        tick();

        check("queues_drained", 32'(fq.size() + lq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer in front of a single-port synchronous instruction memory. It shares the memory between the CPU fetch port (read-only) and the program-loader port (read/write, used for boot loading and debug readback). It grants at most one access per cycle, routes each 1-cycle-latency read response back to its owner, and caps loader bursts so fetch is never starved.

## Interface
- `Width`, 32, address bus width (byte addresses)
- `InctWidth`, 32, data word width
- `InctNum`, 1024, memory depth in words; `AW = $clog2(InctNum)`
- `MaxBurst`, 4, maximum consecutive loader grants while fetch is requesting (1..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `f_req`  in  1  fetch request
- `f_addr`  in  Width  fetch byte address
- `f_gnt`  out  1  fetch request accepted this cycle
- `f_rvalid`  out  1  fetch read data valid
- `f_rdata`  out  InctWidth  fetch read data
- `l_req`  in  1  loader request
- `l_we`  in  1  loader write (1) / read (0)
- `l_addr`  in  Width  loader byte address
- `l_wdata`  in  InctWidth  loader write data
- `l_gnt`  out  1  loader request accepted this cycle
- `l_rvalid`  out  1  loader read data valid (reads only)
- `l_rdata`  out  InctWidth  loader read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  word address, `addr[AW+1:2]`
- `mem_wdata`  out  InctWidth  memory write data
- `mem_rdata`  in  InctWidth  memory read data, valid the cycle after a read `mem_en`
- `err_range`  out  1  sticky: a granted access had word index ≥ InctNum

## Operation
- `f_gnt`, `l_gnt` and `mem_*` are combinational from the requests and the registered state. At most one grant per cycle.
- FSM states:
  - `S_IDLE`: no grant last cycle.
  - `S_FETCH`: fetch granted last cycle.
  - `S_LOAD`: loader granted last cycle.
- Arbitration (evaluated each cycle):
  - Only one requester: grant it.
  - Both requesting: the loader has priority unless `burst_cnt == MaxBurst`, in which case fetch wins.
  - Next state follows the winner; `S_IDLE` if there was no request.
- `burst_cnt` (4 bits):
  - Increments on a loader grant while `f_req` = 1.
  - Clears on any fetch grant or on any cycle with `f_req` = 0.
  - Saturates at `MaxBurst`.
- Grant drives memory:
  - `mem_en` = 1.
  - `mem_we` = 1 only for a loader write.
  - `mem_addr` and `mem_wdata` come from the winner.
- Out of range (`addr[Width-1:2] ≥ InctNum`):
  - The access is still granted, but `mem_en` is held 0.
  - A read returns rdata = 0 with normal rvalid timing.
  - `err_range` is set.
- Response routing uses the registered `rd_owner` (NONE/FETCH/LOAD), captured on a read grant:
  - The next cycle pulses that port's rvalid.
  - rdata is taken from `mem_rdata`, or 0 if the access was out of range.
  - Loader writes produce no rvalid.
- Back-to-back grants are fully pipelined: a new grant in the same cycle as a response is legal.
- The rdata outputs of the non-owner port hold their last value.

## Timing
- Grant latency: 0 cycles (same cycle as `req`). Read data latency: 1 cycle after the grant. Throughput: 1 access per cycle.
- Requesters hold `req`, `addr`, `we` and `wdata` stable until `gnt`. The arbiter does not register the request.
- Reset values:
  - State `S_IDLE`, `burst_cnt` = 0, `rd_owner` = NONE.
  - `f_rvalid` = `l_rvalid` = 0, `f_rdata` = `l_rdata` = 0, `err_range` = 0.
  - `gnt` and `mem_*` outputs follow from reset state and inputs: `mem_en` = 0 while no request.
- Reset asserted mid-read: the pending response is dropped and no rvalid appears after release.
- Simultaneous fetch and loader requests at `burst_cnt == MaxBurst`: fetch is granted and `burst_cnt` clears that cycle.

## Configuration
- `IMEM_ARB_ALIGN_CHECK_EN` defined:
  - Adds output `err_align` (1 bit, sticky, reset 0).
  - A request with `addr[1:0] != 0` is granted but not performed: `mem_en` = 0, a read returns 0, and `err_align` is set.
- Not defined:
  - No `err_align` port.
  - `addr[1:0]` is ignored (word-truncated), as in the memory itself.

## Structure
- Shared package `imem_pkg`: owner encoding (`OWN_NONE`/`OWN_FETCH`/`OWN_LOAD`), FSM state encoding, default `InctWidth`/`InctNum`.
- One natural sub-module: `imem_prio_sel`, a combinational two-requester winner select with burst cap, reused later for data-memory arbitration.
- The memory itself stays a separate instance. `mem_rdata` timing assumes a registered-read variant of the instruction memory.

## Test plan
- Reset then fetch only: `f_addr` = 0x8, memory word 2 = 0x00500093 → `f_gnt` same cycle; next cycle `f_rvalid` = 1, `f_rdata` = 0x00500093.
- Loader write 0xDEADBEEF to 0x10, then loader read 0x10 → `mem_we` = 1 on the first grant only; `l_rvalid` one cycle after the read grant with 0xDEADBEEF; `f_rvalid` stays 0.
- Both requesting continuously, `MaxBurst` = 4 → grant sequence L,L,L,L,F,L,L,L,L,F; fetch is never starved beyond 4 cycles.
- Out of range: `f_addr` = 4·InctNum → `f_gnt` = 1, `mem_en` = 0, next cycle `f_rdata` = 0, `err_range` = 1 and stays set.
- `rst_n` dropped the cycle after a loader read grant → no `l_rvalid`; all outputs return to reset values asynchronously.
- With `IMEM_ARB_ALIGN_CHECK_EN`: `f_addr` = 0x6 → `mem_en` = 0, `f_rdata` = 0, `err_align` = 1. Without the macro: `mem_addr` = 1 and real data is returned.
